mod_addsub_ctrl: RTL and testbench

Sequencer that drives the shared multi-cycle 514-bit `adder` to produce modular results for the RSA datapath: (A+B) mod M, (A−B) mod M, and A/2 mod M (M odd). Each operation issues one or two adder passes, uses the sign of the first pass to choose the correction, and returns a reduced result with a done pulse. It sits between the exponentiation/Montgomery control and the adder, whose ports it drives as master.

---
 rtl/rsa_pkg.sv | 23 ++
 rtl/mod_addsub_ctrl.sv | 145 ++++++++++++++
 tb/tb_mod_addsub_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared encodings for the RSA datapath controllers: operation codes,
// modular add/sub controller state encoding and the default operand width.
package rsa_pkg;

    localparam int RSA_WIDTH = 512;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_HALF = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE1 = 3'd1,
        WAIT1  = 3'd2,
        ISSUE2 = 3'd3,
        WAIT2  = 3'd4,
        FIN    = 3'd5
    } state_t;

endpackage

// File: rtl/mod_addsub_ctrl.sv
// Modular add / subtract / halve sequencer that drives the shared multi-cycle
// adder as master: one or two adder passes, sign of pass 1 picks the correction.
module mod_addsub_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   m,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               err,
    output logic               add_start,
    output logic               add_subtract,
    output logic               add_shift,
    output logic [WIDTH+1:0]   add_in_a,
    output logic [WIDTH+1:0]   add_in_b,
    input  logic [WIDTH+2:0]   add_result,
    input  logic               add_done,
    output state_t             dbg_state
);

    state_t           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH+1:0] r1_q, r1_d;
    logic             pend2_q, pend2_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [WIDTH+1:0] in_a_q, in_a_d;
    logic [WIDTH+1:0] in_b_q, in_b_d;
    logic             sub_q, sub_d;
    logic             shift_q, shift_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            m_q      <= '0;
            r1_q     <= '0;
            pend2_q  <= 1'b0;
            result_q <= '0;
            err_q    <= 1'b0;
            in_a_q   <= '0;
            in_b_q   <= '0;
            sub_q    <= 1'b0;
            shift_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            m_q      <= m_d;
            r1_q     <= r1_d;
            pend2_q  <= pend2_d;
            result_q <= result_d;
            err_q    <= err_d;
            in_a_q   <= in_a_d;
            in_b_q   <= in_b_d;
            sub_q    <= sub_d;
            shift_q  <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        m_d      = m_q;
        r1_d     = r1_q;
        pend2_d  = pend2_q;
        result_d = result_q;
        err_d    = err_q;
        in_a_d   = in_a_q;
        in_b_d   = in_b_q;
        sub_d    = sub_q;
        shift_d  = shift_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op_e'(op);
                    m_d      = m;
                    err_d    = (op_e'(op) == OP_RSVD);
                    result_d = '0;
                    if (op_e'(op) == OP_RSVD) begin
                        state_d = FIN;
                    end else begin
                        // Pass-1 operands are loaded at acceptance so ISSUE1 can fire at once.
                        in_a_d  = {2'b00, a};
                        if (op_e'(op) == OP_HALF) in_b_d = a[0] ? {2'b00, m} : '0;
                        else                      in_b_d = {2'b00, b};
                        sub_d   = (op_e'(op) == OP_SUB);
                        shift_d = (op_e'(op) == OP_HALF);
                        state_d = ISSUE1;
                    end
                end
            end
            ISSUE1: state_d = WAIT1;
            WAIT1: begin
                if (pend2_q) begin
                    // Pass-2 operands come from the registered r1, one cycle after capture.
                    pend2_d = 1'b0;
                    in_a_d  = r1_q;
                    in_b_d  = {2'b00, m_q};
                    sub_d   = (op_q == OP_ADD);
                    shift_d = 1'b0;
                    state_d = ISSUE2;
                end else if (add_done) begin
                    r1_d = add_result[WIDTH+1:0];
                    if (op_q == OP_ADD || (op_q == OP_SUB && add_result[WIDTH+2])) begin
                        pend2_d = 1'b1;
                    end else begin
                        result_d = add_result[WIDTH-1:0];
                        state_d  = FIN;
                    end
                end
            end
            ISSUE2: state_d = WAIT2;
            WAIT2: begin
                if (add_done) begin
                    if (op_q == OP_ADD && add_result[WIDTH+2]) result_d = r1_q[WIDTH-1:0];
                    else                                     result_d = add_result[WIDTH-1:0];
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FIN);
    assign result       = result_q;
    assign err          = err_q;
    assign add_start    = (state_q == ISSUE1) || (state_q == ISSUE2);
    assign add_subtract = sub_q;
    assign add_shift    = shift_q;
    assign add_in_a     = in_a_q;
    assign add_in_b     = in_b_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Bench for mod_addsub_ctrl: behavioural adder with programmable latency,
// arithmetic reference model, scoreboard queue and directed plus random ops.
module tb_mod_addsub_ctrl;
    import rsa_pkg::*;

    localparam int W  = 512;
    localparam int CW = W + 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [1:0]     op = 2'b00;
    logic [W-1:0]   a = '0, b = '0, m = '0;
    logic           busy, done, err;
    logic [W-1:0]   result;
    logic           add_start, add_subtract, add_shift;
    logic [W+1:0]   add_in_a, add_in_b;
    logic [W+2:0]   add_result;
    logic           add_done;
    state_t         dbg_state;

    int             n_checks = 0;
    int             n_errors = 0;
    int             lat = 3;
    int             adder_cnt;
    int             start_cnt = 0;
    logic [W+1:0]   pb_q[$];
    logic           ps_q[$];
    logic [W-1:0]   exp_q[$];

    always #5 clk = ~clk;

    mod_addsub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .m(m),
        .busy(busy), .done(done), .result(result), .err(err),
        .add_start(add_start), .add_subtract(add_subtract), .add_shift(add_shift),
        .add_in_a(add_in_a), .add_in_b(add_in_b),
        .add_result(add_result), .add_done(add_done),
        .dbg_state(dbg_state)
    );

    // Behavioural adder: add_done lands exactly lat cycles after add_start.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            adder_cnt  <= 0;
            add_done   <= 1'b0;
            add_result <= '0;
        end else begin
            add_done <= 1'b0;
            if (add_start) begin
                logic signed [W+2:0] s;
                s = add_subtract ? ($signed({1'b0, add_in_a}) - $signed({1'b0, add_in_b}))
                                 : ($signed({1'b0, add_in_a}) + $signed({1'b0, add_in_b}));
                if (add_shift) s = s >>> 1;
                add_result <= s;
                adder_cnt  <= lat - 1;
                if (lat == 1) add_done <= 1'b1;
            end else if (adder_cnt > 0) begin
                adder_cnt <= adder_cnt - 1;
                if (adder_cnt == 1) add_done <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && add_start) begin
            start_cnt <= start_cnt + 1;
            pb_q.push_back(add_in_b);
            ps_q.push_back(add_shift);
        end
    end

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] x,
                                               input logic [W-1:0] y, input logic [W-1:0] md);
        logic [W:0] s;
        case (o)
            2'b00: begin
                s = {1'b0, x} + {1'b0, y};
                if (s >= {1'b0, md}) s = s - {1'b0, md};
            end
            2'b01:   s = (x >= y) ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, md} - {1'b0, y};
            2'b10:   s = x[0] ? (({1'b0, x} + {1'b0, md}) >> 1) : ({1'b0, x} >> 1);
            default: s = '0;
        endcase
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, CW'(busy), '0);
        check({tag, "_done"}, CW'(done), '0);
        check({tag, "_err"}, CW'(err), '0);
        check({tag, "_result"}, CW'(result), '0);
        check({tag, "_add_ctl"}, CW'({add_start, add_subtract, add_shift}), '0);
        check({tag, "_add_in"}, CW'(add_in_a | add_in_b), '0);
    endtask

    // poke=1: extra start pulses in WAIT1 (cycle 3) and in the FIN cycle.
    // rst_at>0: assert reset in that cycle and check outputs clear at once.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] im, input int poke, input int rst_at);
        int n, s0, b0, exp_lat, exp_passes;
        logic [W-1:0] exp_r, got_r;
        bit seen;
        exp_q.push_back(ref_model(o, ia, ib, im));
        case (o)
            2'b00:   begin exp_lat = 4 + 2 * lat; exp_passes = 2; end
            2'b01:   begin
                exp_lat    = (ia < ib) ? 4 + 2 * lat : 2 + lat;
                exp_passes = (ia < ib) ? 2 : 1;
            end
            2'b10:   begin exp_lat = 2 + lat; exp_passes = 1; end
            default: begin exp_lat = 1; exp_passes = 0; end
        endcase
        @(negedge clk);
        s0 = start_cnt;
        b0 = pb_q.size();
        start = 1'b1; op = o; a = ia; b = ib; m = im;
        @(negedge clk);
        start = 1'b0; op = 2'($urandom); a = rand_w(); b = rand_w(); m = rand_w();
        n = 1;
        check("busy_c1", CW'(busy), CW'(1));
        seen = 0;
        while (n < 300) begin
            if (rst_at == n) begin
                reset = 1'b1;
                #1;
                check_all_zero("mid_reset");
                @(negedge clk);
                reset = 1'b0;
                void'(exp_q.pop_back());
                return;
            end
            if (poke == 1 && n == 3) begin
                start = 1'b1; op = 2'b01; a = rand_w(); b = rand_w(); m = rand_w();
            end
            if (poke == 1 && n == 4) start = 1'b0;
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (!seen) begin
            check("done_timeout", CW'(0), CW'(1));
            void'(exp_q.pop_front());
            return;
        end
        exp_r = exp_q.pop_front();
        got_r = result;
        check("result", CW'(got_r), CW'(exp_r));
        check("latency", CW'(n), CW'(exp_lat));
        check("err", CW'(err), CW'(o == 2'b11));
        check("passes", CW'(start_cnt - s0), CW'(exp_passes));
        if (o == 2'b10 && pb_q.size() > b0) begin
            check("half_in_b", CW'(pb_q[b0]), CW'(ia[0] ? {2'b00, im} : {(W+2){1'b0}}));
            check("half_shift", CW'(ps_q[b0]), CW'(1));
        end
        if (poke == 1) begin
            start = 1'b1; op = 2'b00; a = rand_w(); b = rand_w(); m = rand_w();
            @(negedge clk);
            start = 1'b0;
            check("fin_start_ignored", CW'(busy), CW'(0));
            check("result_hold", CW'(result), CW'(exp_r));
        end
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] rm, ra, rb;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        lat = 3;
        do_op(2'b00, 7, 9, 13, 0, 0);
        do_op(2'b01, 3, 9, 13, 0, 0);
        do_op(2'b01, 9, 3, 13, 0, 0);
        do_op(2'b10, 7, 0, 13, 0, 0);
        do_op(2'b10, 6, 0, 13, 0, 0);
        do_op(2'b11, 5, 5, 13, 0, 0);
        do_op(2'b00, 12, 0, 13, 0, 0);
        do_op(2'b00, 7, 9, 13, 1, 0);
        do_op(2'b00, 5, 6, 13, 0, 8);
        do_op(2'b00, 12, 12, 13, 0, 0);

        for (int i = 0; i < 40; i++) begin
            lat = $urandom_range(1, 5);
            ro  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) rm = W'($urandom_range(1, 500)) | W'(1);
            else                           rm = rand_w() | W'(1);
            ra = rand_w() % rm;
            rb = ($urandom_range(0, 4) == 0) ? ra : rand_w() % rm;
            do_op(ro, ra, rb, rm, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
